// File: rtl/life_scan_ctrl.sv
// Scan-chain controller for a 16-cell life array: serially loads or reads back the array
// while holding off evolution. Optional post-load readback check enabled by LIFE_SCAN_VERIFY_EN.
module life_scan_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] wr_data,
  input  logic        run_req,
  input  logic        scan_read_val,
  output logic        scan,
  output logic        scan_write_val,
  output logic        scan_write_enb,
  output logic        run,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data
`ifdef LIFE_SCAN_VERIFY_EN
  ,
  output logic        verify_err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_DONE   = 2'd2,
    S_VERIFY = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic [15:0] wr_q, wr_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] rd_q, rd_d;
  logic [3:0]  idx;
  logic        last;
  logic        accept;

  // Cells travel MSB first, so cycle k addresses bit 15-k.
  assign idx    = 4'd15 - cnt_q;
  assign last   = (cnt_q == 4'd15);
  assign accept = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last) begin
`ifdef LIFE_SCAN_VERIFY_EN
        state_d = mode_q ? S_VERIFY : S_DONE;
`else
        state_d = S_DONE;
`endif
      end
      S_VERIFY: if (last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    scan           = 1'b0;
    scan_write_val = 1'b0;
    scan_write_enb = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    if (!reset) begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
      scan = (state_q == S_SHIFT) || (state_q == S_VERIFY);
      if (state_q == S_SHIFT) begin
        scan_write_val = wr_q[idx];
        scan_write_enb = mode_q;
      end
    end
  end

  // The array must never evolve while its cells are in flight on the chain.
  assign run     = run_req && !busy && !reset;
  assign rd_data = rd_q;

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wr_d   = wr_q;
    cap_d  = cap_q;
    rd_d   = rd_q;
    if (accept) begin
      cnt_d  = 4'd0;
      mode_d = mode;
      wr_d   = wr_data;
    end
    if (state_q == S_SHIFT || state_q == S_VERIFY) cnt_d = cnt_q + 4'd1;
    if (state_q == S_SHIFT) cap_d[idx] = scan_read_val;
    if (state_q == S_DONE)  rd_d = cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      mode_q <= 1'b0;
      wr_q   <= 16'h0000;
      cap_q  <= 16'h0000;
      rd_q   <= 16'h0000;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      wr_q   <= wr_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end

`ifdef LIFE_SCAN_VERIFY_EN
  logic acc_q, acc_d;
  logic verr_q, verr_d;

  always_comb begin
    acc_d  = acc_q;
    verr_d = verr_q;
    if (accept) begin
      acc_d  = 1'b0;
      verr_d = 1'b0;
    end
    if (state_q == S_VERIFY && (scan_read_val != wr_q[idx])) acc_d = 1'b1;
    if (state_q == S_DONE) verr_d = acc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      verr_q <= verr_d;
    end
  end

  assign verify_err = verr_q;
`endif

endmodule

// File: doc/life_scan_ctrl.md
LIFE_SCAN_CTRL -- requirements
Module: life_scan_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; every flop samples on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a scan pass; sampled only in IDLE.
REQ-004 SHALL have port mode, input, 1; 1 = LOAD (write pattern into array), 0 = READ (non-destructive readback); sampled with start.
REQ-005 SHALL have port wr_data, input, 16, pattern to load; sampled with start.
REQ-006 SHALL have port run_req, input, 1, user request to let the array evolve.
REQ-007 SHALL have port scan_read_val, input, 1, serial cell value returned by the array.
REQ-008 SHALL have port scan, output, 1, shift-enable to the array.
REQ-009 SHALL have port scan_write_val, output, 1, serial cell value into the array.
REQ-010 SHALL have port scan_write_enb, output, 1; 1 = array takes scan_write_val, 0 = array recirculates its shifted-out cell.
REQ-011 SHALL have port run, output, 1, gated run to the array.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port rd_data, output, 16, pattern captured during the last completed pass.

Function
REQ-015 SHALL implement states IDLE, SHIFT, DONE (and VERIFY when configured).
REQ-016 IDLE: start=1 SHALL latch mode and wr_data, clear the 4-bit bit counter, and go to SHIFT next cycle.
REQ-017 SHIFT SHALL last exactly 16 cycles with scan=1 throughout; scan=0 in every other state.
REQ-018 In SHIFT cycle k (k=0..15), scan_write_val SHALL equal latched wr_data[15-k], i.e. MSB first.
REQ-019 scan_write_enb SHALL equal 1 in SHIFT only when the latched mode is LOAD; it SHALL be 0 in READ and in all other states.
REQ-020 In SHIFT cycle k, scan_read_val SHALL be captured into capture-register bit 15-k.
REQ-021 The counter SHALL increment each SHIFT cycle; on its terminal count 15 the FSM SHALL leave SHIFT. The counter SHALL wrap to 0 and never exceed 15.
REQ-022 DONE SHALL last one cycle: done=1, rd_data loaded from the capture register, then IDLE.
REQ-023 Latency: start sampled at edge N -> scan high for cycles N+1..N+16 -> done high in cycle N+17 -> busy low from N+18.
REQ-024 start while busy SHALL be ignored, with no queuing.
REQ-025 run SHALL equal run_req AND NOT busy, so the array never evolves during a scan.
REQ-026 In LOAD, rd_data SHALL hold the array contents as they were before the load, since the old contents are shifted out.
REQ-027 A start arriving in the same cycle that DONE returns to IDLE SHALL NOT be accepted; it is accepted only when sampled in IDLE.

Reset
REQ-028 reset SHALL force IDLE, counter=0, and rd_data=16'h0000.
REQ-029 reset SHALL force scan, scan_write_val, scan_write_enb, done, busy, and run to 0, overriding run_req.
REQ-030 reset mid-SHIFT SHALL abort the pass, produce no done pulse, and leave rd_data at 0.

Configuration
REQ-031 With macro LIFE_SCAN_VERIFY_EN defined, a LOAD pass SHALL be followed by VERIFY: 16 further scan cycles with scan_write_enb=0, comparing scan_read_val to wr_data[15-k].
REQ-032 With LIFE_SCAN_VERIFY_EN defined, a 1-bit output verify_err SHALL be present. It SHALL be set in DONE on any mismatch, cleared on start or reset, and done SHALL be delayed by 16 cycles for LOAD.
REQ-033 Without LIFE_SCAN_VERIFY_EN, neither VERIFY nor verify_err SHALL exist, and the timing of REQ-023 SHALL apply to both modes.

Verification
REQ-034 Reset, LOAD wr_data=16'h6600, then READ -> READ done with rd_data=16'h6600; array alive=16'h6600.
REQ-035 LOAD 16'h8001 over array holding 16'h6186 -> rd_data=16'h6186, then READ gives 16'h8001; scan high exactly 16 cycles per pass.
REQ-036 start pulsed again at shift cycle 5 -> ignored; done exactly once, at cycle N+17.
REQ-037 run_req=1 held across a READ -> run=0 for cycles N+1..N+17, 1 otherwise.
REQ-038 reset asserted at shift cycle 8 -> next cycle IDLE, all outputs 0, no done pulse, rd_data=0.
REQ-039 With LIFE_SCAN_VERIFY_EN defined: LOAD 16'h2664 -> done at N+33 with verify_err=0; a forced scan_read_val mismatch -> verify_err=1.
